uart_apb_ctrl: RTL and testbench
================================

# uart_apb_ctrl

APB3 slave controller that sequences all CPU access to the UART: it turns APB transfers into single-cycle TX-FIFO pushes and RX-FIFO pops, owns the CTRL and STATUS registers, launches the transmitter, and raises the UART interrupt. It sits between the SoC APB bus and the UART TX/RX FIFOs and transmitter, and is the only agent that drives their enables.

## Interface
- TIMEOUT, 16, maximum wait cycles on a full TX FIFO before the transfer errors out (≥2)
- clk  in  1  system clock
- rst  in  1  reset; one clock domain, asynchronous assert, active-high
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  4  byte address: 0 TXDATA (W), 4 RXDATA (R), 8 STATUS (R/W1C), 12 CTRL (R/W)
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  transfer complete, registered
- PSLVERR  out  1  error, valid only with PREADY
- wr_full_tx, rd_empty_tx, tx_busy  in  1 each  TX FIFO and transmitter status
- wr_en_tx  out  1  TX FIFO push strobe; tx_data  out  8  = PWDATA[7:0] latched
- start_tx  out  1  transmitter launch pulse
- rd_empty_rx, wr_full_rx, data_valid  in  1 each  RX FIFO status and receiver byte strobe
- rd_en_rx  out  1  RX FIFO pop strobe; rx_data  in  8  FIFO output, valid the cycle after rd_en_rx
- irq  out  1  level interrupt, registered

## Operation
- States: IDLE, DECODE, TX_WAIT, RX_POP, RESP.
- IDLE → DECODE on PSEL & !PENABLE. DECODE acts only when PSEL & PENABLE.
- Errors (PREADY=1, PSLVERR=1, no side effect, → RESP): PADDR[1:0]≠0; write to RXDATA; read of TXDATA; TXDATA write with CTRL.tx_en=0; RXDATA read with CTRL.rx_en=0 or rd_empty_rx=1 (PRDATA=0).
- TXDATA write, not full: wr_en_tx=1, tx_data=PWDATA[7:0], PREADY=1 → RESP. Full: → TX_WAIT, counter cleared.
- TX_WAIT: each cycle, if !wr_full_tx, do the push above. Otherwise, when counter = TIMEOUT-1: PREADY=1, PSLVERR=1, no push → RESP.
- RXDATA read, non-empty: rd_en_rx=1 → RX_POP. RX_POP: PRDATA={24'b0, rx_data}, PREADY=1 → RESP.
- STATUS read: PRDATA={26'b0, overrun, tx_busy, wr_full_tx, rd_empty_tx, wr_full_rx, rd_empty_rx}.
- STATUS write: bit5=1 clears overrun. Other bits are ignored.
- CTRL (reset 0): [0] tx_en, [1] rx_en, [2] rx_irq_en, [3] tx_irq_en. Bits [31:4] read 0.
- STATUS/CTRL accesses: PREADY=1 → RESP.
- RESP: PREADY, PSLVERR, wr_en_tx and rd_en_rx all return to 0 → IDLE. PRDATA holds its value until the next read.
- overrun: sticky. Set on data_valid & wr_full_rx. If set and W1C occur in the same cycle, set wins.
- start_tx launch rule:
  - Pulse for 1 cycle when tx_en & !rd_empty_tx & !tx_busy & !launched.
  - launched is set by start_tx and cleared when tx_busy=1.
  - This gives no double launch during the start-to-busy gap.
- irq = (rx_irq_en & !rd_empty_rx) | (tx_irq_en & rd_empty_tx & !tx_busy) | overrun, registered.

## Timing
- All outputs are registered. Reset value of every output, CTRL, overrun, launched and the counter is 0; state resets to IDLE.
- Setup cycle T0, access T1.
- Register, error and non-full TX write: PREADY high in T2, so the transfer takes 3 cycles. wr_en_tx is high in T2 only.
- RX read: rd_en_rx high in T2, PREADY and PRDATA valid in T3.
- Full-FIFO timeout: PREADY in T2+TIMEOUT.
- PREADY is never high for 2 consecutive cycles.
- PSEL dropped mid-transfer (protocol violation): return to IDLE without side effects, unless a strobe has already been issued.
- Reset mid-transfer: immediate return to IDLE with outputs 0. The transfer is lost and no strobe completes.
- start_tx: earliest 1 cycle after the condition holds. irq lags its sources by 1 cycle.

## Structure
- Package uart_ctrl_pkg holds:
  - Address offsets TXDATA/RXDATA/STATUS/CTRL.
  - State enum.
  - CTRL and STATUS bit indices.
  - Default TIMEOUT.
- One sub-module, uart_tx_launch: tx_en, rd_empty_tx and tx_busy in; start_tx and the launched flag logic out.

## Test plan
- Reset mid-TX_WAIT → all outputs 0 next cycle, no wr_en_tx, state IDLE.
- CTRL=0x3, write 0x41 to TXDATA with FIFO not full → wr_en_tx 1 cycle with tx_data=0x41, PREADY in T2, PSLVERR=0. Then, with rd_empty_tx=0 and tx_busy=0, exactly one start_tx before tx_busy rises.
- TXDATA write with wr_full_tx held 1 → PREADY+PSLVERR at T2+16, no wr_en_tx. Same test with full released at T2+5 → push and PREADY at T2+6, PSLVERR=0.
- RX FIFO holding 0x5A, read RXDATA → rd_en_rx in T2, PRDATA=0x0000005A with PREADY in T3. Read again with rd_empty_rx=1 → PSLVERR=1, PRDATA=0.
- Pulse data_valid with wr_full_rx=1 → STATUS reads 0x20|flags and irq=1. Write 0x20 to STATUS → overrun and irq clear. Set and W1C in the same cycle → overrun stays 1.
- Accesses to PADDR=2 (misaligned) and to a write of RXDATA → PSLVERR=1, CTRL unchanged.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared definitions for the UART APB controller.
//   - register byte offsets on the APB window
//   - controller state encoding
//   - CTRL / STATUS bit positions
//   - default full-FIFO wait limit
//   - status_word(): packs the STATUS register read value
package uart_ctrl_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_CTRL   = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_TX_WAIT = 3'd2,
    ST_RX_POP  = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_RX_IRQ_EN = 2;
  localparam int CTRL_TX_IRQ_EN = 3;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_TX_BUSY  = 4;
  localparam int STAT_OVERRUN  = 5;

  function automatic logic [31:0] status_word(
    input logic overrun,
    input logic tx_busy,
    input logic tx_full,
    input logic tx_empty,
    input logic rx_full,
    input logic rx_empty
  );
    logic [31:0] w;
    w                = 32'h0000_0000;
    w[STAT_OVERRUN]  = overrun;
    w[STAT_TX_BUSY]  = tx_busy;
    w[STAT_TX_FULL]  = tx_full;
    w[STAT_TX_EMPTY] = tx_empty;
    w[STAT_RX_FULL]  = rx_full;
    w[STAT_RX_EMPTY] = rx_empty;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_launch.sv
// uart_tx_launch: issues a one-cycle transmitter launch pulse when the
// transmitter is enabled, idle and the TX FIFO holds data.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   tx_en_i         CTRL.tx_en
//   rd_empty_tx_i   TX FIFO empty
//   tx_busy_i       transmitter busy
//   start_tx_o      registered launch pulse
module uart_tx_launch (
  input  logic clk,
  input  logic rst,
  input  logic tx_en_i,
  input  logic rd_empty_tx_i,
  input  logic tx_busy_i,
  output logic start_tx_o
);

  logic start_q, start_d;
  logic launched_q, launched_d;

  // Launch decision; launched is raised together with the pulse so the
  // cycles between start_tx and tx_busy rising cannot launch again.
  always_comb begin
    start_d = tx_en_i & ~rd_empty_tx_i & ~tx_busy_i & ~launched_q;
    if (tx_busy_i) begin
      launched_d = 1'b0;
    end else begin
      launched_d = launched_q | start_d;
    end
  end

  // Launch pulse and launched flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q    <= 1'b0;
      launched_q <= 1'b0;
    end else begin
      start_q    <= start_d;
      launched_q <= launched_d;
    end
  end

  assign start_tx_o = start_q;

endmodule

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB3 slave sequencing CPU access to the UART FIFOs.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request
//   PRDATA/PREADY/PSLVERR         APB response (registered)
//   wr_full_tx, rd_empty_tx, tx_busy  TX FIFO / transmitter status
//   wr_en_tx, tx_data, start_tx   TX FIFO push and transmitter launch
//   rd_empty_rx, wr_full_rx, data_valid, rx_data  RX FIFO / receiver
//   rd_en_rx                      RX FIFO pop strobe
//   irq                           level interrupt (registered)
module uart_apb_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        wr_full_tx,
  input  logic        rd_empty_tx,
  input  logic        tx_busy,
  output logic        wr_en_tx,
  output logic [7:0]  tx_data,
  output logic        start_tx,
  input  logic        rd_empty_rx,
  input  logic        wr_full_rx,
  input  logic        data_valid,
  output logic        rd_en_rx,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          overrun_q, overrun_d;
  logic [31:0]   prdata_q, prdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic          wr_en_tx_q, wr_en_tx_d;
  logic          rd_en_rx_q, rd_en_rx_d;
  logic          irq_q, irq_d;
  logic          w1c_s;
  logic          err_s;
  logic          unused_pwdata_s;

  assign unused_pwdata_s = ^PWDATA[31:8];

  // Transfer sequencer: next state, response and FIFO strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    prdata_d   = prdata_q;
    tx_data_d  = tx_data_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    wr_en_tx_d = 1'b0;
    rd_en_rx_d = 1'b0;
    w1c_s      = 1'b0;
    err_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
          if (PADDR[1:0] != 2'b00) begin
            err_s = 1'b1;
          end else begin
            case (PADDR)
              ADDR_TXDATA: begin
                if (!PWRITE || !ctrl_q[CTRL_TX_EN]) begin
                  err_s = 1'b1;
                end else begin
                  tx_data_d = PWDATA[7:0];
                  if (wr_full_tx) begin
                    pready_d = 1'b0;
                    state_d  = ST_TX_WAIT;
                    cnt_d    = '0;
                  end else begin
                    wr_en_tx_d = 1'b1;
                  end
                end
              end
              ADDR_RXDATA: begin
                if (PWRITE || !ctrl_q[CTRL_RX_EN] || rd_empty_rx) begin
                  err_s = 1'b1;
                end else begin
                  // Response waits one cycle for the popped byte.
                  pready_d   = 1'b0;
                  rd_en_rx_d = 1'b1;
                  state_d    = ST_RX_POP;
                end
              end
              ADDR_STATUS: begin
                if (PWRITE) begin
                  w1c_s = PWDATA[STAT_OVERRUN];
                end else begin
                  prdata_d = status_word(overrun_q, tx_busy, wr_full_tx,
                                         rd_empty_tx, wr_full_rx, rd_empty_rx);
                end
              end
              ADDR_CTRL: begin
                if (PWRITE) begin
                  ctrl_d = PWDATA[3:0];
                end else begin
                  prdata_d = {28'h000_0000, ctrl_q};
                end
              end
              default: begin
                err_s = 1'b1;
              end
            endcase
          end
          // Errored reads return zero; errored writes leave PRDATA alone.
          if (err_s) begin
            pslverr_d = 1'b1;
            if (!PWRITE) begin
              prdata_d = 32'h0000_0000;
            end else begin
              prdata_d = prdata_q;
            end
          end else begin
            pslverr_d = 1'b0;
          end
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_TX_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (!wr_full_tx) begin
          wr_en_tx_d = 1'b1;
          pready_d   = 1'b1;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RX_POP: begin
        prdata_d = {24'h00_0000, rx_data};
        pready_d = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky overrun (a new overrun beats a same-cycle clear) and interrupt.
  always_comb begin
    overrun_d = (overrun_q & ~w1c_s) | (data_valid & wr_full_rx);
    irq_d     = (ctrl_q[CTRL_RX_IRQ_EN] & ~rd_empty_rx)
              | (ctrl_q[CTRL_TX_IRQ_EN] & rd_empty_tx & ~tx_busy)
              | overrun_q;
  end

  // State, register file and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ctrl_q     <= 4'h0;
      overrun_q  <= 1'b0;
      prdata_q   <= 32'h0000_0000;
      tx_data_q  <= 8'h00;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      wr_en_tx_q <= 1'b0;
      rd_en_rx_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      overrun_q  <= overrun_d;
      prdata_q   <= prdata_d;
      tx_data_q  <= tx_data_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      wr_en_tx_q <= wr_en_tx_d;
      rd_en_rx_q <= rd_en_rx_d;
      irq_q      <= irq_d;
    end
  end

  uart_tx_launch u_launch (
    .clk           (clk),
    .rst           (rst),
    .tx_en_i       (ctrl_q[CTRL_TX_EN]),
    .rd_empty_tx_i (rd_empty_tx),
    .tx_busy_i     (tx_busy),
    .start_tx_o    (start_tx)
  );

  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign wr_en_tx = wr_en_tx_q;
  assign tx_data  = tx_data_q;
  assign rd_en_rx = rd_en_rx_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Testbench for uart_apb_ctrl: directed scenarios plus randomized APB
// traffic checked against a register-level reference model through
// response / push scoreboards.
module tb_uart_apb_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0]  PADDR = 4'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        wr_full_tx = 1'b0, rd_empty_tx = 1'b1, tx_busy = 1'b0;
  logic        wr_en_tx, start_tx, rd_en_rx, irq;
  logic [7:0]  tx_data;
  logic        rd_empty_rx = 1'b1, wr_full_rx = 1'b0, data_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  uart_apb_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .wr_full_tx(wr_full_tx), .rd_empty_tx(rd_empty_tx), .tx_busy(tx_busy),
    .wr_en_tx(wr_en_tx), .tx_data(tx_data), .start_tx(start_tx),
    .rd_empty_rx(rd_empty_rx), .wr_full_rx(wr_full_rx),
    .data_valid(data_valid), .rd_en_rx(rd_en_rx), .rx_data(rx_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          lat;
    bit          push;
    bit          pop;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int         ctrl_m = 0;
  bit         overrun_m = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_start = 0;
  bit         prev_ready = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sync_rx();
    rd_empty_rx = (rxq.size() == 0);
    rx_data     = rd_empty_rx ? 8'h00 : rxq[0];
  endtask

  function automatic bit irq_model();
    return (((ctrl_m >> 2) & 1) != 0 && rxq.size() != 0)
        || (((ctrl_m >> 3) & 1) != 0 && rd_empty_tx && !tx_busy)
        || overrun_m;
  endfunction

  // Reference model of one APB access; rel = cycle at which a full TX FIFO frees (0: not full).
  function automatic exp_t model(input bit w, input logic [3:0] a, input int rel);
    exp_t e;
    int   v;
    e.rd = !w; e.err = 1'b0; e.data = 32'h0; e.lat = 1; e.push = 1'b0; e.pop = 1'b0;
    if (a % 4 != 0) begin
      e.err = 1'b1;
    end else if (a == 4'd0) begin
      if (!w || (ctrl_m & 1) == 0) e.err = 1'b1;
      else if (rel == 0) e.push = 1'b1;
      else if (rel <= TO) begin e.push = 1'b1; e.lat = rel + 1; end
      else begin e.err = 1'b1; e.lat = TO + 1; end
    end else if (a == 4'd4) begin
      if (w || ((ctrl_m >> 1) & 1) == 0 || rxq.size() == 0) e.err = 1'b1;
      else begin e.pop = 1'b1; e.lat = 2; e.data = {24'h0, rxq[0]}; end
    end else if (a == 4'd8) begin
      v = (overrun_m ? 32 : 0) + (tx_busy ? 16 : 0) + (rel != 0 ? 8 : 0)
        + (rd_empty_tx ? 4 : 0) + (wr_full_rx ? 2 : 0) + (rxq.size() == 0 ? 1 : 0);
      e.data = v;
    end else begin
      e.data = ctrl_m;
    end
    return e;
  endfunction

  task automatic apb(input bit w, input logic [3:0] a, input logic [31:0] d,
                     input int rel, input bit dv_t1);
    exp_t e;
    int   cyc, wr_cyc, rd_cyc;
    wr_full_tx = (rel != 0);
    e = model(w, a, rel);
    exp_q.push_back(e);
    if (e.push) txq.push_back(d[7:0]);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    if (dv_t1) begin data_valid = 1'b1; wr_full_rx = 1'b1; end
    cyc = 0; wr_cyc = -1; rd_cyc = -1;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (dv_t1) begin data_valid = 1'b0; wr_full_rx = 1'b0; end
      if (wr_en_tx) wr_cyc = cyc;
      if (rd_en_rx) rd_cyc = cyc;
      if (rel != 0 && cyc == rel) wr_full_tx = 1'b0;
    end while (!PREADY && cyc < 100);
    cmp("latency", cyc, e.lat);
    cmp("wr_en_cycle", wr_cyc, e.push ? e.lat : -1);
    cmp("rd_en_cycle", rd_cyc, e.pop ? 1 : -1);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; wr_full_tx = 1'b0;
    if (!e.err && w && a == 4'd12) ctrl_m = d[3:0];
    if (!e.err && w && a == 4'd8 && d[5]) overrun_m = 1'b0;
    if (dv_t1) overrun_m = 1'b1;
    if (e.pop) begin void'(rxq.pop_front()); sync_rx(); end
  endtask

  task automatic pulse_dv(input bit f);
    bit old;
    old = wr_full_rx;
    @(posedge clk); #1;
    data_valid = 1'b1; wr_full_rx = f;
    @(posedge clk); #1;
    data_valid = 1'b0; wr_full_rx = old;
    if (f) overrun_m = 1'b1;
  endtask

  task automatic check_irq(input string nm);
    repeat (3) @(posedge clk);
    #1;
    cmp(nm, irq, irq_model());
  endtask

  // Response scoreboard and strobe monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (PREADY) begin
        cmp("pready_not_back_to_back", prev_ready, 1'b0);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pready: got 1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          cmp("pslverr", PSLVERR, e.err);
          if (e.rd) cmp("prdata", PRDATA, e.data);
        end
      end else if (PSLVERR) begin
        n_tests++; n_fail++;
        $display("FAIL pslverr_without_pready: got 1 expected 0 at %0t", $time);
      end
      if (wr_en_tx) begin
        if (txq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_wr_en_tx: got 1 expected 0 at %0t", $time);
        end else begin
          cmp("tx_data", tx_data, txq.pop_front());
        end
      end
      if (start_tx) n_start++;
      prev_ready = PREADY;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [3:0] a;
    bit w;
    int rel;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("reset_ctl_outs", {PREADY, PSLVERR, wr_en_tx, rd_en_rx, start_tx, irq}, 32'h0);
    cmp("reset_prdata", PRDATA, 32'h0);
    cmp("reset_tx_data", tx_data, 32'h0);

    // Reset while waiting on a full TX FIFO.
    apb(1'b1, 4'd12, 32'h3, 0, 1'b0);
    wr_full_tx = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h0; PWDATA = 32'h77;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp("rst_mid_ctl_outs", {PREADY, PSLVERR, wr_en_tx, rd_en_rx, start_tx, irq}, 32'h0);
    cmp("rst_mid_prdata", PRDATA, 32'h0);
    cmp("rst_mid_tx_data", tx_data, 32'h0);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; wr_full_tx = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ctrl_m = 0; overrun_m = 1'b0;
    apb(1'b0, 4'd12, 32'h0, 0, 1'b0);

    // TX push and single launch.
    apb(1'b1, 4'd12, 32'h3, 0, 1'b0);
    apb(1'b1, 4'd0, 32'h41, 0, 1'b0);
    s0 = n_start;
    rd_empty_tx = 1'b0; tx_busy = 1'b0;
    repeat (5) @(posedge clk);
    #1 tx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rd_empty_tx = 1'b1; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 cmp("start_tx_count", n_start - s0, 1);

    // Full TX FIFO: timeout, then release at T2+5.
    apb(1'b1, 4'd0, 32'h99, 1000, 1'b0);
    apb(1'b1, 4'd0, 32'h5C, 6, 1'b0);

    // RX read, then read on empty FIFO.
    rxq.push_back(8'h5A); sync_rx();
    apb(1'b0, 4'd4, 32'h0, 0, 1'b0);
    apb(1'b0, 4'd4, 32'h0, 0, 1'b0);

    // Overrun set, read, W1C, and set/clear collision.
    pulse_dv(1'b1);
    check_irq("irq_overrun_set");
    apb(1'b0, 4'd8, 32'h0, 0, 1'b0);
    apb(1'b1, 4'd8, 32'h20, 0, 1'b0);
    check_irq("irq_overrun_clr");
    apb(1'b0, 4'd8, 32'h0, 0, 1'b0);
    apb(1'b1, 4'd8, 32'h20, 0, 1'b1);
    apb(1'b0, 4'd8, 32'h0, 0, 1'b0);
    apb(1'b1, 4'd8, 32'h20, 0, 1'b0);

    // Misaligned and illegal-direction accesses leave CTRL intact.
    apb(1'b1, 4'd2, 32'hF, 0, 1'b0);
    apb(1'b0, 4'd2, 32'h0, 0, 1'b0);
    apb(1'b1, 4'd4, 32'hC, 0, 1'b0);
    apb(1'b0, 4'd0, 32'h0, 0, 1'b0);
    apb(1'b0, 4'd12, 32'h0, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      rd_empty_tx = $urandom_range(0, 1);
      tx_busy     = $urandom_range(0, 1);
      wr_full_rx  = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0 && rxq.size() < 4) begin
        rxq.push_back(8'($urandom_range(0, 255)));
        sync_rx();
      end
      if ($urandom_range(0, 5) == 0) pulse_dv($urandom_range(0, 1));
      check_irq("irq_random");
      if ($urandom_range(0, 3) != 0) a = 4'($urandom_range(0, 3) * 4);
      else a = 4'($urandom_range(0, 15));
      w   = $urandom_range(0, 1);
      rel = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      apb(w, a, $urandom, rel, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    cmp("resp_queue_drained", exp_q.size(), 0);
    cmp("push_queue_drained", txq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
